// File: rtl/dmp_pkg.sv
// Shared types and helpers for the pagerank stream serializer.
// Holds the serializer state encoding, iteration counter width and a clog2 helper.
package dmp_pkg;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    SEND      = 2'd1,
    DONE      = 2'd2
  } dmp_ser_state_t;

  localparam int DMP_ITER_W = 16;

  function automatic int dmp_clog2_min1(input int n);
    int c;
    c = $clog2(n);
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/dmp_next_thread.sv
// Combinational priority finder: lowest set bit of mask strictly above idx.
// Ports: mask, idx (signed, -1 = search from bit 0) -> nxt index, found flag.
module dmp_next_thread
  import dmp_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0]        mask,
  input  logic signed [W:0]   idx,
  output logic [W-1:0]        nxt,
  output logic                found
);

  // Scan downward so the lowest qualifying bit is the last one written.
  always_comb begin
    nxt   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(idx))) begin
        nxt   = W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmp_stream_serializer.sv
// Waits for all active gather threads, then streams each thread's vector as LANES-wide beats.
// Ports: clock/reset, next_iteration, active_mask, gather_*, out_* valid/ready stream, status.
module dmp_stream_serializer
  import dmp_pkg::*;
#(
  parameter int NUM_HW_THREADS = 8,
  parameter int NODES_IN_GRAPH = 32,
  parameter int DATA_W         = 64,
  parameter int LANES          = 8,
  localparam int THREAD_W      = dmp_clog2_min1(NUM_HW_THREADS),
  localparam int BEATS         = NODES_IN_GRAPH / LANES,
  localparam int BEAT_W        = dmp_clog2_min1(BEATS)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         next_iteration,
  input  logic [NUM_HW_THREADS-1:0]    active_mask,
  input  logic [NUM_HW_THREADS-1:0][NODES_IN_GRAPH-1:0][DATA_W-1:0] gather_data,
  input  logic [NUM_HW_THREADS-1:0]    gather_done,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES-1:0][DATA_W-1:0] out_data,
  output logic [THREAD_W-1:0]          out_thread,
  output logic [BEAT_W-1:0]            out_beat,
  output logic                         out_first,
  output logic                         out_last,
  output logic                         stream_start,
  output logic                         stream_done,
  output logic [DMP_ITER_W-1:0]        iteration_count
);

  localparam int NODE_W = dmp_clog2_min1(NODES_IN_GRAPH);

  if (NUM_HW_THREADS < 1) begin : g_bad_threads
    $error("NUM_HW_THREADS must be at least 1");
  end
  if ((NODES_IN_GRAPH % LANES) != 0) begin : g_bad_lanes
    $error("LANES must divide NODES_IN_GRAPH");
  end

  dmp_ser_state_t state_q, state_d;
  logic [THREAD_W-1:0]       thread_q, thread_d;
  logic [BEAT_W-1:0]         beat_q, beat_d;
  logic [NUM_HW_THREADS-1:0] mask_q, mask_d;
  logic [DMP_ITER_W-1:0]     iter_q, iter_d;

  logic                      sync;
  logic                      send;
  logic                      last_beat;
  logic [NUM_HW_THREADS-1:0] first_mask;
  logic [THREAD_W-1:0]       first_idx;
  logic                      first_found;
  logic [THREAD_W-1:0]       nx_idx;
  logic                      nx_found;

  assign sync      = &(gather_done | ~active_mask);
  assign send      = (state_q == SEND);
  assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

  // One finder serves both jobs: picking the first thread from the live
  // mask while waiting, and naming the first latched thread while sending.
  assign first_mask = send ? mask_q : active_mask;

  dmp_next_thread #(
    .N (NUM_HW_THREADS),
    .W (THREAD_W)
  ) u_first (
    .mask  (first_mask),
    .idx   ('1),
    .nxt   (first_idx),
    .found (first_found)
  );

  dmp_next_thread #(
    .N (NUM_HW_THREADS),
    .W (THREAD_W)
  ) u_next (
    .mask  (mask_q),
    .idx   ($signed({1'b0, thread_q})),
    .nxt   (nx_idx),
    .found (nx_found)
  );

  always_comb begin
    state_d  = state_q;
    thread_d = thread_q;
    beat_d   = beat_q;
    mask_d   = mask_q;
    iter_d   = iter_q;
    unique case (state_q)
      WAIT_SYNC: begin
        if (sync) begin
          if (first_found) begin
            state_d  = SEND;
            mask_d   = active_mask;
            thread_d = first_idx;
            beat_d   = '0;
          end else begin
            state_d = DONE;
            iter_d  = iter_q + 16'd1;
          end
        end
      end
      SEND: begin
        if (out_ready) begin
          if (last_beat) begin
            beat_d = '0;
            if (nx_found) begin
              thread_d = nx_idx;
            end else begin
              state_d = DONE;
              iter_d  = iter_q + 16'd1;
            end
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      DONE: begin
        if (next_iteration) begin
          state_d = WAIT_SYNC;
        end
      end
      default: state_d = WAIT_SYNC;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= WAIT_SYNC;
      thread_q <= '0;
      beat_q   <= '0;
      mask_q   <= '0;
      iter_q   <= '0;
    end else begin
      state_q  <= state_d;
      thread_q <= thread_d;
      beat_q   <= beat_d;
      mask_q   <= mask_d;
      iter_q   <= iter_d;
    end
  end

  always_comb begin
    out_data = '0;
    for (int l = 0; l < LANES; l++) begin
      if (send) begin
        out_data[l] = gather_data[thread_q]
                      [NODE_W'(int'(beat_q) * LANES + l)];
      end
    end
  end

  assign out_valid       = send;
  assign out_thread      = send ? thread_q : '0;
  assign out_beat        = send ? beat_q : '0;
  assign out_first       = send && (beat_q == '0);
  assign out_last        = send && last_beat;
  assign stream_start    = out_first && (thread_q == first_idx);
  assign stream_done     = (state_q == DONE);
  assign iteration_count = iter_q;

endmodule

// File: tb/tb_dmp_stream_serializer.sv
// Self-checking bench for dmp_stream_serializer with default parameters.
// Expected beat order is built from the mask as a queue of (thread, beat) pairs.
module tb_dmp_stream_serializer;

  logic clock = 1'b0;
  logic reset;
  logic next_iteration;
  logic [7:0] active_mask;
  logic [7:0][31:0][63:0] gather_data;
  logic [7:0] gather_done;
  logic out_valid;
  logic out_ready;
  logic [7:0][63:0] out_data;
  logic [2:0] out_thread;
  logic [1:0] out_beat;
  logic out_first;
  logic out_last;
  logic stream_start;
  logic stream_done;
  logic [15:0] iteration_count;

  int total = 0;
  int bad = 0;
  logic [15:0] iter_exp;

  dmp_stream_serializer dut (
    .clock           (clock),
    .reset           (reset),
    .next_iteration  (next_iteration),
    .active_mask     (active_mask),
    .gather_data     (gather_data),
    .gather_done     (gather_done),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_thread      (out_thread),
    .out_beat        (out_beat),
    .out_first       (out_first),
    .out_last        (out_last),
    .stream_start    (stream_start),
    .stream_done     (stream_done),
    .iteration_count (iteration_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_data();
    for (int t = 0; t < 8; t++)
      for (int n = 0; n < 32; n++)
        gather_data[t][n] = {$urandom, $urandom};
  endtask

  // Entered at a negedge with the DUT already in SEND.
  task automatic stream(input logic [7:0] m, input int rdy_pct,
                        input int stop_n, input bit pulse_nx);
    int t_q[$];
    int b_q[$];
    int n;
    int cyc;
    int beats;
    n = 0;
    cyc = 0;
    for (int t = 0; t < 8; t++)
      if (m[t])
        for (int b = 0; b < 4; b++) begin
          t_q.push_back(t);
          b_q.push_back(b);
        end
    beats = t_q.size();
    while (t_q.size() > 0) begin
      if (cyc > 2000) begin
        chk("stream_timeout", 64'(t_q.size()), 64'd0);
        break;
      end
      chk("valid", 64'(out_valid), 64'd1);
      chk("thread", 64'(out_thread), 64'(t_q[0]));
      chk("beat", 64'(out_beat), 64'(b_q[0]));
      chk("first", 64'(out_first), 64'(b_q[0] == 0));
      chk("last", 64'(out_last), 64'(b_q[0] == 3));
      chk("start", 64'(stream_start), 64'(n == 0));
      chk("done_in_send", 64'(stream_done), 64'd0);
      for (int l = 0; l < 8; l++)
        chk($sformatf("data_t%0d_b%0d_l%0d", t_q[0], b_q[0], l),
            out_data[l], gather_data[t_q[0]][b_q[0] * 8 + l]);
      out_ready = ($urandom_range(0, 99) < rdy_pct);
      next_iteration = pulse_nx && (cyc == 2);
      @(posedge clock);
      if (out_ready) begin
        void'(t_q.pop_front());
        void'(b_q.pop_front());
        n++;
      end
      cyc++;
      @(negedge clock);
      next_iteration = 1'b0;
      if (stop_n > 0 && n == stop_n) return;
    end
    out_ready = 1'b1;
    iter_exp++;
    if (rdy_pct >= 100) chk("cycles", 64'(cyc), 64'(beats));
    chk("end_done", 64'(stream_done), 64'd1);
    chk("end_valid", 64'(out_valid), 64'd0);
    chk("end_count", 64'(iteration_count), 64'(iter_exp));
    chk("end_thread", 64'(out_thread), 64'd0);
    chk("end_start", 64'(stream_start), 64'd0);
  endtask

  // From DONE: pulse next_iteration, then present the new done vector.
  task automatic rearm(input logic [7:0] m, input logic [7:0] d);
    next_iteration = 1'b1;
    active_mask = m;
    gather_done = '0;
    fill_data();
    @(posedge clock);
    @(negedge clock);
    next_iteration = 1'b0;
    chk("rearm_valid", 64'(out_valid), 64'd0);
    chk("rearm_done", 64'(stream_done), 64'd0);
    gather_done = d;
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1;
    next_iteration = 1'b0;
    out_ready = 1'b1;
    active_mask = 8'hFF;
    gather_done = 8'h00;
    iter_exp = '0;
    fill_data();
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_done", 64'(stream_done), 64'd0);
    chk("rst_count", 64'(iteration_count), 64'd0);
    chk("rst_thread", 64'(out_thread), 64'd0);
    chk("rst_beat", 64'(out_beat), 64'd0);
    chk("rst_first", 64'(out_first), 64'd0);
    chk("rst_start", 64'(stream_start), 64'd0);
    chk("rst_data", out_data[0], 64'd0);
    reset = 1'b0;

    // Staggered gather completion, full mask.
    for (int t = 0; t < 8; t++) begin
      gather_done[t] = 1'b1;
      if (t < 7) begin
        repeat (2) begin
          @(posedge clock);
          @(negedge clock);
          chk("early_valid", 64'(out_valid), 64'd0);
        end
      end else begin
        @(posedge clock);
        @(negedge clock);
      end
    end
    stream(8'hFF, 100, 0, 1'b0);

    // DONE holds without next_iteration.
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("done_hold", 64'(stream_done), 64'd1);

    // Backpressure, with a next_iteration pulse mid-stream.
    rearm(8'hFF, 8'hFF);
    stream(8'hFF, 50, 0, 1'b1);

    // Sparse mask; later mask/done changes must not affect the stream.
    rearm(8'hA4, 8'hA4);
    active_mask = 8'hFF;
    gather_done = 8'h00;
    stream(8'hA4, 70, 0, 1'b0);

    // Empty mask goes straight to DONE.
    rearm(8'h00, 8'h00);
    iter_exp++;
    chk("empty_done", 64'(stream_done), 64'd1);
    chk("empty_valid", 64'(out_valid), 64'd0);
    chk("empty_count", 64'(iteration_count), 64'(iter_exp));

    // Counter wrap.
    force dut.iter_q = 16'hFFFF;
    #1;
    release dut.iter_q;
    iter_exp = 16'hFFFF;
    chk("wrap_preset", 64'(iteration_count), 64'(iter_exp));
    rearm(8'h00, 8'h00);
    iter_exp++;
    chk("wrap_count", 64'(iteration_count), 64'(iter_exp));

    // Reset after 10 of 32 beats, then a clean restart.
    rearm(8'hFF, 8'hFF);
    stream(8'hFF, 100, 10, 1'b0);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    iter_exp = '0;
    chk("abort_valid", 64'(out_valid), 64'd0);
    chk("abort_count", 64'(iteration_count), 64'(iter_exp));
    chk("abort_done", 64'(stream_done), 64'd0);
    chk("abort_beat", 64'(out_beat), 64'd0);
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    stream(8'hFF, 80, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
